// File: rtl/serial_to_8way.sv
// serial_to_8way
// Deserializer: shifts single bits from a 1-bit valid/ready stream into an
// 8-bit word and presents the word plus its OR-reduction on a valid/ready
// output. The output register is a second buffer, so the next word can
// assemble while the previous one waits for the consumer.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous reset, active low
//   in_bit_i     serial data bit
//   in_valid_i   in_bit_i is valid this cycle
//   in_ready_o   block accepts in_bit_i this cycle
//   out_o        assembled word {a,b,c,d,e,f,g,h} = out_o[7:0]
//   out_any_o    OR of all bits of out_o, registered with out_o
//   out_valid_o  out_o / out_any_o hold a complete word
//   out_ready_i  consumer takes the word this cycle
//
// Output register FSM
//   state    | meaning
//   ST_EMPTY | no word held, out_valid_o = 0
//   ST_FULL  | complete word held in out_o, out_valid_o = 1

module serial_to_8way #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_o,
  output logic             out_any_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_any_q, out_any_d;

  logic             accept;
  logic             consume;
  logic             complete;
  logic [WIDTH-1:0] sr_shift;

  assign out_valid_o = (state_q == ST_FULL);

  // Only the completing bit can stall: it needs the output register free,
  // either already empty or being emptied on this same edge.
  assign in_ready_o = !((cnt_q == CNT_LAST) && out_valid_o && !out_ready_i);

  assign accept   = in_valid_i && in_ready_o;
  assign consume  = out_valid_o && out_ready_i;
  assign complete = accept && (cnt_q == CNT_LAST);

  // MSB-first: the first bit enters at bit 0 and is pushed up to the top.
  // LSB-first: the first bit enters at the top and is pushed down to bit 0.
  assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], in_bit_i}
                              : {in_bit_i, sr_q[WIDTH-1:1]};

  // Shift register and bit counter
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (accept) begin
      sr_d  = sr_shift;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Output register: loads the word including the completing bit. When a
  // word is held, completion can only happen together with a consume, so
  // the held value is never overwritten before it is taken.
  always_comb begin
    out_d     = out_q;
    out_any_d = out_any_q;
    if (complete) begin
      out_d     = sr_shift;
      out_any_d = |sr_shift;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete) state_d = ST_FULL;
      end
      ST_FULL: begin
        // consume + completion on the same edge stays FULL with no bubble
        if (consume && !complete) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_EMPTY;
      sr_q      <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_any_q <= out_any_d;
    end
  end

  assign out_o     = out_q;
  assign out_any_o = out_any_q;

endmodule

// File: doc/serial_to_8way.md
# serial_to_8way

Serial-to-parallel deserializer: collects single bits from a 1-bit stream into one 8-bit word `{a,b,c,d,e,f,g,h}` and presents the word, with an 8-way OR flag, over a valid/ready handshake. It is the fan-out counterpart of the 8-way OR reduction. It sits between a 1-bit serial source and any consumer of 8-bit parallel words, such as Or8Way, Mux8Way16 or the register files. The block double-buffers, so a new word can assemble while the previous one waits for the consumer.

## Interface
- `WIDTH`, 8, word width. Only 8 is supported; the parameter documents the width.
- `MSB_FIRST`, 1. When 1, the first received bit lands in `out[7]` (bit `a`). When 0, the first received bit lands in `out[0]` (bit `h`).
- `clk`  input  1  clock, rising-edge active.
- `rst_n`  input  1  asynchronous reset, active-low.
- `in_bit`  input  1  serial data bit.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_ready`  output  1  block accepts `in_bit` this cycle.
- `out`  output  8  assembled word.
- `out_any`  output  1  OR of all 8 bits of `out`, registered together with `out`.
- `out_valid`  output  1  `out` and `out_any` hold a complete word.
- `out_ready`  input  1  consumer takes the word this cycle.

## Operation
- Accept and consume events:
  - An input bit is accepted when `in_valid && in_ready`.
  - An output word is consumed when `out_valid && out_ready`.
- Shift register `sr[7:0]` and 3-bit counter `cnt` (0..7):
  - Each accepted bit shifts into `sr` in the direction set by `MSB_FIRST`.
  - Each accepted bit increments `cnt`. `cnt` wraps 7 -> 0 on the 8th bit.
- Word completion:
  - The 8th accepted bit, at `cnt == 7`, completes the word.
  - On completion, the full word, including the 8th bit, is loaded into the output register `out`.
  - `out_any` = `|word` is loaded on the same edge.
  - `out_valid` is set on the same edge.
- Output register states:
  - EMPTY: `out_valid = 0`.
  - FULL: `out_valid = 1`.
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on consume with no completion in the same cycle.
  - FULL -> FULL on consume and completion in the same cycle. The new word replaces the old one with no bubble, and `out_valid` stays 1.
- Backpressure:
  - `in_ready = !(cnt == 7 && out_valid && !out_ready)`.
  - Bits 1..7 of the next word are always accepted while a word is held.
  - Only the completing bit stalls.
- Holding rule: while `out_valid` is high, `out` and `out_any` do not change except on the simultaneous consume-plus-completion case.
- Bits presented with `in_valid = 0` are ignored. `sr` and `cnt` hold.
- Partial words are never emitted. There is no flush input.

## Timing
- Reset (`rst_n` low, asynchronous): `cnt = 0`, `sr = 0`, `out = 8'h00`, `out_any = 0`, `out_valid = 0`. `in_ready = 1` combinationally from the reset state.
- Reset mid-word or mid-hold: the partial word and any held word are discarded. After release, the next accepted bit is bit 1 of a new word.
- Latency: `out_valid` rises on the clock edge that accepts the 8th bit. The word is visible in the cycle after that edge.
- Minimum word period is 8 cycles. With `out_ready` held at 1, the sustained throughput is 1 bit per cycle.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` or `in_bit` to any output.
- Output and handshake rules:
  - `out_valid` never drops without a consume or a reset.
  - `out_ready` may be asserted while `out_valid = 0`. It has no effect.

## Test plan
- Reset: drive `rst_n = 0` with random inputs -> `out = 8'h00`, `out_any = 0`, `out_valid = 0`, `in_ready = 1`. Release reset and send 8 bits 1,1,1,1,1,1,1,1 with `out_ready = 1` -> `out = 8'hFF`, `out_any = 1`, `out_valid` high for 1 cycle.
- Patterns, MSB_FIRST = 1, gaps inserted in `in_valid`: send 8'b00000000, then 8'b00010000, then 8'b00000001, then 8'b00100110 -> `out` = 8'h00 / 8'h10 / 8'h01 / 8'h26, `out_any` = 0 / 1 / 1 / 1.
- Backpressure: hold `out_ready = 0` and stream 16 bits, word 8'hA5 then word 8'h3C:
  - `out` = 8'hA5 and holds.
  - Bits 9..15 are accepted.
  - `in_ready = 0` while the 16th bit is presented.
  - Raise `out_ready` for one cycle -> 8'hA5 is consumed and the 16th bit is accepted on the same edge; `out` = 8'h3C with `out_valid` still 1.
- Simultaneous event: with 8'h0F held, assert `out_ready` on the cycle the 8th bit of 8'hF0 is accepted -> `out` goes 8'h0F -> 8'hF0 with no `out_valid` gap.
- Reset mid-operation:
  - Assert `rst_n` low after 5 bits of a word, with a word also held -> `out_valid = 0`.
  - Release and send 8'h81 -> `out = 8'h81`, with no bits left over from before the reset.
- MSB_FIRST = 0: send bits 1,0,0,0,0,0,0,0 in that order -> `out = 8'h01`, `out_any = 1`.
